// File: rtl/varredura_servo_pkg.sv
// Shared definitions for the servo sweep: FSM state encodings, position limits
// and the default dwell length.
package varredura_servo_pkg;

    typedef enum logic [1:0] {
        INICIAL = 2'b00,
        ESPERA  = 2'b01,
        AVANCA  = 2'b10
    } estado_t;

    localparam logic [2:0] POS_MAX         = 3'd7;
    localparam logic [2:0] POS_MIN         = 3'd0;
    localparam int         M_DWELL_DEFAULT = 100_000_000;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the terminal count M-1.
module contador_m #(
    parameter int M = 10,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         fim
);

    localparam logic [N-1:0] Q_MAX = N'(M - 1);

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            Q <= '0;
        end else if (conta) begin
            Q <= (Q == Q_MAX) ? '0 : Q + N'(1);
        end
    end

    assign fim = (Q == Q_MAX);

endmodule

// File: rtl/varredura_servo.sv
// Triangle sweep of a 3-bit servo position 0..7..0, holding each position for
// M_DWELL cycles and pulsing pronto in the last cycle of every dwell.
module varredura_servo
    import varredura_servo_pkg::*;
#(
    parameter int M_DWELL = M_DWELL_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    output logic [2:0] posicao,
    output logic       pronto,
    output logic       sentido,
    output logic [1:0] db_estado
);

    localparam int            CW   = (M_DWELL > 2) ? $clog2(M_DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(M_DWELL - 2);

    estado_t       estado_reg, estado_next;
    logic [CW-1:0] contagem;
    logic          fim_contagem;
    logic          zera, conta;
    logic [2:0]    posicao_reg;
    logic          sentido_reg;

    // Counts 0..M_DWELL-2 across the ESPERA cycles of one dwell.
    contador_m #(
        .M (M_DWELL - 1),
        .N (CW)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .Q     (contagem),
        .fim   (fim_contagem)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next = INICIAL;
        case (estado_reg)
            INICIAL: estado_next = ligar ? ESPERA : INICIAL;
            ESPERA: begin
                if (!ligar)
                    estado_next = INICIAL;
                else if (contagem == LAST)
                    estado_next = AVANCA;
                else
                    estado_next = ESPERA;
            end
            AVANCA:  estado_next = ligar ? ESPERA : INICIAL;
            default: estado_next = INICIAL;
        endcase
    end

    // Counter is cleared on every edge that does not stay in / enter ESPERA,
    // so each ESPERA run starts from zero.
    always_comb begin
        pronto    = (estado_reg == AVANCA);
        db_estado = estado_reg;
        conta     = (estado_reg == ESPERA) && !fim_contagem;
        zera      = (estado_next != ESPERA);
    end

    // Abort and reset both win over the step taken when leaving AVANCA.
    always_ff @(posedge clock) begin
        if (reset || estado_next == INICIAL) begin
            posicao_reg <= POS_MIN;
            sentido_reg <= 1'b1;
        end else if (estado_reg == AVANCA) begin
            if (sentido_reg) begin
                if (posicao_reg == POS_MAX) begin
                    posicao_reg <= POS_MAX - 3'd1;
                    sentido_reg <= 1'b0;
                end else begin
                    posicao_reg <= posicao_reg + 3'd1;
                end
            end else begin
                if (posicao_reg == POS_MIN) begin
                    posicao_reg <= POS_MIN + 3'd1;
                    sentido_reg <= 1'b1;
                end else begin
                    posicao_reg <= posicao_reg - 3'd1;
                end
            end
        end
    end

    assign posicao = posicao_reg;
    assign sentido = sentido_reg;

endmodule

// File: tb/tb_varredura_servo.sv
// Self-checking bench for varredura_servo with a short dwell: table of input
// segments with expected end values, a per-cycle scoreboard, and a sweep sequence.
module tb_varredura_servo;

    localparam int M = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic [2:0] posicao;
    logic       pronto;
    logic       sentido;
    logic [1:0] db_estado;

    always #10 clock = ~clock;

    varredura_servo #(.M_DWELL(M)) dut (
        .clock     (clock),
        .reset     (reset),
        .ligar     (ligar),
        .posicao   (posicao),
        .pronto    (pronto),
        .sentido   (sentido),
        .db_estado (db_estado)
    );

    typedef struct packed {
        logic [2:0] pos;
        logic       sent;
        logic       pr;
        logic [1:0] est;
    } saida_t;

    typedef struct packed {
        logic       r;
        logic       l;
        logic [7:0] n;
        logic [2:0] pos;
        logic       sent;
        logic [1:0] est;
    } vec_t;

    saida_t fila[$];
    vec_t   tab[$];
    int     checks = 0;
    int     errors = 0;
    int     ciclo  = 0;

    // Reference model: phase within the current dwell (0..M-1), position, direction.
    bit m_run   = 1'b0;
    int m_phase = 0;
    int m_pos   = 0;
    bit m_dir   = 1'b1;

    task automatic check(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, atual, esperado, ciclo);
        end
    endtask

    task automatic model_step(input logic r, input logic l);
        if (r || !l) begin
            m_run = 1'b0; m_phase = 0; m_pos = 0; m_dir = 1'b1;
        end else if (!m_run) begin
            m_run = 1'b1; m_phase = 0;
        end else if (m_phase == M - 1) begin
            m_phase = 0;
            if (m_dir) begin
                if (m_pos == 7) begin m_pos = 6; m_dir = 1'b0; end
                else m_pos = m_pos + 1;
            end else begin
                if (m_pos == 0) begin m_pos = 1; m_dir = 1'b1; end
                else m_pos = m_pos - 1;
            end
        end else begin
            m_phase = m_phase + 1;
        end
    endtask

    task automatic tick(input logic r, input logic l);
        saida_t e, o;
        reset = r;
        ligar = l;
        model_step(r, l);
        e.pos  = 3'(m_pos);
        e.sent = m_dir;
        e.pr   = m_run && (m_phase == M - 1);
        e.est  = !m_run ? 2'b00 : ((m_phase == M - 1) ? 2'b10 : 2'b01);
        fila.push_back(e);
        @(posedge clock);
        #1;
        ciclo++;
        o = {posicao, sentido, pronto, db_estado};
        e = fila.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL cycle: cycle %0d got pos=%0d sent=%0b pr=%0b est=%0d, expected pos=%0d sent=%0b pr=%0b est=%0d",
                     ciclo, o.pos, o.sent, o.pr, o.est, e.pos, e.sent, e.pr, e.est);
        end
    endtask

    task automatic add_row(input logic r, input logic l, input int n,
                           input int pos, input logic sent, input int est);
        vec_t v;
        v.r = r; v.l = l; v.n = 8'(n); v.pos = 3'(pos); v.sent = sent; v.est = 2'(est);
        tab.push_back(v);
    endtask

    int seen_pos[20];
    int seen_sent[20];
    int seen_hold[20];
    int nseen;
    int last_pronto;
    int npronto;
    int exp_seq[16];

    initial begin
        reset = 1'b1;
        ligar = 1'b0;

        add_row(1, 0,  1, 0, 1, 0);   // reset pulse
        add_row(0, 0, 20, 0, 1, 0);   // parked while disabled
        add_row(0, 1,  1, 0, 1, 1);   // enter ESPERA
        add_row(0, 1,  9, 0, 1, 2);   // end of first dwell: AVANCA
        add_row(0, 1,  1, 1, 1, 1);   // first step
        add_row(0, 1, 60, 7, 1, 1);   // up to the top
        add_row(0, 1, 10, 6, 0, 1);   // turn at 7
        add_row(0, 1, 64, 0, 0, 1);   // down to 0
        add_row(0, 1,  6, 1, 1, 1);   // turn at 0
        add_row(0, 1, 43, 5, 1, 1);   // mid-dwell at 5
        add_row(0, 0,  1, 0, 1, 0);   // abort in ESPERA
        add_row(0, 1,  1, 0, 1, 1);
        add_row(0, 1,  9, 0, 1, 2);   // full dwell after restart
        add_row(0, 1,  1, 1, 1, 1);
        add_row(0, 1,  9, 1, 1, 2);   // in AVANCA
        add_row(0, 0,  1, 0, 1, 0);   // abort beats the step
        add_row(0, 1,  1, 0, 1, 1);
        add_row(0, 1,  9, 0, 1, 2);   // in AVANCA
        add_row(1, 1,  1, 0, 1, 0);   // reset beats the step
        add_row(0, 1,  1, 0, 1, 1);

        for (int i = 0; i < tab.size(); i++) begin
            for (int k = 0; k < int'(tab[i].n); k++)
                tick(tab[i].r, tab[i].l);
            check($sformatf("row%0d_pos", i), int'(posicao), int'(tab[i].pos));
            check($sformatf("row%0d_sent", i), int'(sentido), int'(tab[i].sent));
            check($sformatf("row%0d_est", i), int'(db_estado), int'(tab[i].est));
            $display("row %0d: reset=%0b ligar=%0b cycles=%0d -> pos=%0d sent=%0b est=%0d",
                     i, tab[i].r, tab[i].l, tab[i].n, posicao, sentido, db_estado);
        end

        // Full sweep: record each distinct position, its direction and hold length.
        exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        tick(1'b1, 1'b0);
        nseen = 1;
        seen_pos[0] = int'(posicao); seen_sent[0] = int'(sentido); seen_hold[0] = 1;
        last_pronto = -1;
        npronto = 0;
        for (int c = 0; c < 160; c++) begin
            tick(1'b0, 1'b1);
            if (pronto) begin
                if (last_pronto >= 0)
                    check("pronto_period", ciclo - last_pronto, M);
                last_pronto = ciclo;
                npronto++;
            end
            if (int'(posicao) != seen_pos[nseen-1]) begin
                if (nseen < 20) begin
                    seen_pos[nseen]  = int'(posicao);
                    seen_sent[nseen] = int'(sentido);
                    seen_hold[nseen] = 1;
                    nseen++;
                end
            end else begin
                seen_hold[nseen-1]++;
            end
        end
        check("sweep_pronto_count", npronto, 16);
        check("sweep_len_ok", int'(nseen >= 16), 1);
        if (nseen >= 16) begin
            for (int k = 0; k < 16; k++)
                check($sformatf("sweep_pos%0d", k), seen_pos[k], exp_seq[k]);
            for (int k = 1; k < 15; k++)
                check($sformatf("sweep_hold%0d", k), seen_hold[k], M);
            check("sweep_sent_at7", seen_sent[7], 1);
            check("sweep_sent_7to6", seen_sent[8], 0);
            check("sweep_sent_at0", seen_sent[14], 0);
            check("sweep_sent_0to1", seen_sent[15], 1);
        end
        $display("sweep: %0d positions seen, %0d pronto pulses", nseen, npronto);

        check("queue_empty", fila.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
